// File: rtl/gpio_pkg.sv
// Shared definitions for the gpio_ctrl_v2 GPIO controller: register map,
// interrupt mode encoding and bus byte-lane helpers.
package gpio_pkg;

   localparam logic [3:0] GPIO_DIR      = 4'd0;
   localparam logic [3:0] GPIO_OUT      = 4'd1;
   localparam logic [3:0] GPIO_OUT_SET  = 4'd2;
   localparam logic [3:0] GPIO_OUT_CLR  = 4'd3;
   localparam logic [3:0] GPIO_IN       = 4'd4;
   localparam logic [3:0] GPIO_INT_EN   = 4'd5;
   localparam logic [3:0] GPIO_INT_TYPE = 4'd6;
   localparam logic [3:0] GPIO_INT_POL  = 4'd7;
   localparam logic [3:0] GPIO_INT_BOTH = 4'd8;
   localparam logic [3:0] GPIO_INT_STAT = 4'd9;
   localparam logic [3:0] GPIO_DB_PRESC = 4'd10;
   localparam logic [3:0] GPIO_OUT_TYPE = 4'd11;

   localparam int DB_PRESC_W = 16;

   typedef enum logic [2:0] {
      EDGE_POS,
      EDGE_NEG,
      EDGE_BOTH,
      LVL_HIGH,
      LVL_LOW
   } gpio_int_mode_e;

   // Level type takes priority; BOTH only matters for edge-type pins.
   function automatic gpio_int_mode_e int_mode(input logic level, input logic pol,
                                               input logic both);
      if (level) return pol ? LVL_HIGH : LVL_LOW;
      if (both) return EDGE_BOTH;
      return pol ? EDGE_POS : EDGE_NEG;
   endfunction

   function automatic logic [31:0] be_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Pad input synchroniser plus per-pin debounce filter; the filter is only
// built when GPIO_DEBOUNCE_EN is defined, otherwise d is the synchronised input.
module gpio_debounce
   import gpio_pkg::*;
#(
   parameter int GPIO_W      = 32,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CNT      = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick,
   input  logic              bypass,
   input  logic              clr,
   input  logic              load,
   input  logic [GPIO_W-1:0] raw,
   output logic [GPIO_W-1:0] sync,
   output logic [GPIO_W-1:0] d
);

   logic [GPIO_W-1:0] sync_q [SYNC_STAGES];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= raw;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
   localparam logic [3:0] CNT_LAST = 4'(DB_CNT - 1);

   logic [3:0]        cnt_q [GPIO_W];
   logic [GPIO_W-1:0] d_q;

   // A pin's counter only runs while its synchronised value disagrees with d.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d_q <= '0;
         for (int i = 0; i < GPIO_W; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < GPIO_W; i++) begin
            if (load || bypass) begin
               d_q[i]   <= sync[i];
               cnt_q[i] <= '0;
            end else if (clr || (sync[i] == d_q[i])) begin
               cnt_q[i] <= '0;
            end else if (tick) begin
               if (cnt_q[i] == CNT_LAST) begin
                  d_q[i]   <= sync[i];
                  cnt_q[i] <= '0;
               end else begin
                  cnt_q[i] <= cnt_q[i] + 4'd1;
               end
            end
         end
      end
   end

   assign d = bypass ? sync : d_q;
`else
   logic unused_ctl;
   assign unused_ctl = ^{tick, bypass, clr, load, 4'(DB_CNT)};
   assign d = sync;
`endif

endmodule

// File: rtl/gpio_ctrl_v2.sv
// GPIO controller top: register-bus slave, pad output registers and interrupts.
// Optional debounce prescaler/filter and DB_PRESC register under GPIO_DEBOUNCE_EN.
module gpio_ctrl_v2
   import gpio_pkg::*;
#(
   parameter int GPIO_W      = 32,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CNT      = 3
) (
   input  logic              mclk,
   input  logic              h_reset_n,
   input  logic              reg_cs,
   input  logic              reg_wr,
   input  logic [3:0]        reg_addr,
   input  logic [31:0]       reg_wdata,
   input  logic [3:0]        reg_be,
   output logic [31:0]       reg_rdata,
   output logic              reg_ack,
   output logic [GPIO_W-1:0] cfg_gpio_dir_sel,
   output logic [GPIO_W-1:0] cfg_gpio_out_type,
   input  logic [GPIO_W-1:0] pad_gpio_in,
   output logic [GPIO_W-1:0] pad_gpio_out,
   output logic [GPIO_W-1:0] gpio_intr,
   output logic              gpio_irq
);

   localparam logic [2:0] LOAD_END = 3'(SYNC_STAGES + 1);
   localparam logic [2:0] WIN_END  = 3'(SYNC_STAGES + 2);

   logic [GPIO_W-1:0] dir_q, out_q, out_type_q, pad_out_q;
   logic [GPIO_W-1:0] int_en_q, int_type_q, int_pol_q, int_both_q, int_stat_q;
   logic [GPIO_W-1:0] sync, d, prev_q, ev, wsel, w1c;
   logic [31:0]       wmask, wbits, rd_mux;
   logic [2:0]        st_q;
   logic              take, wr_en, load, ev_en;
   logic              tick, bypass, db_clr;

   function automatic logic [GPIO_W-1:0] upd(input logic [GPIO_W-1:0] old,
                                             input logic [31:0] m, input logic [31:0] b);
      return GPIO_W'((32'(old) & ~m) | b);
   endfunction

   assign take  = reg_cs & ~reg_ack;
   assign wr_en = take & reg_wr;
   assign wmask = be_mask(reg_be);
   assign wbits = reg_wdata & wmask;
   assign wsel  = GPIO_W'(wbits);
   assign w1c   = (wr_en && (reg_addr == GPIO_INT_STAT)) ? wsel : '0;

`ifdef GPIO_DEBOUNCE_EN
   logic [DB_PRESC_W-1:0] presc_q, presc_cnt_q;
   logic                  presc_wr;

   assign presc_wr = wr_en && (reg_addr == GPIO_DB_PRESC);
   assign bypass   = (presc_q == '0);
   assign tick     = !bypass && (presc_cnt_q == presc_q);
   assign db_clr   = presc_wr;

   always_ff @(posedge mclk) begin
      if (!h_reset_n) begin
         presc_q     <= '0;
         presc_cnt_q <= '0;
      end else begin
         if (presc_wr) presc_q <= DB_PRESC_W'((32'(presc_q) & ~wmask) | wbits);
         if (presc_wr || bypass || tick) presc_cnt_q <= '0;
         else presc_cnt_q <= presc_cnt_q + 1'b1;
      end
   end
`else
   assign bypass = 1'b1;
   assign tick   = 1'b0;
   assign db_clr = 1'b0;
`endif

   // Startup window: d follows sync directly and the first settling edge is ignored.
   always_ff @(posedge mclk) begin
      if (!h_reset_n) st_q <= '0;
      else if (st_q != WIN_END) st_q <= st_q + 3'd1;
   end

   assign load  = (st_q < LOAD_END);
   assign ev_en = (st_q == WIN_END);

   gpio_debounce #(
      .GPIO_W      (GPIO_W),
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CNT      (DB_CNT)
   ) u_debounce (
      .clk    (mclk),
      .rst_n  (h_reset_n),
      .tick   (tick),
      .bypass (bypass),
      .clr    (db_clr),
      .load   (load),
      .raw    (pad_gpio_in),
      .sync   (sync),
      .d      (d)
   );

   always_comb begin
      ev = '0;
      for (int i = 0; i < GPIO_W; i++) begin
         case (int_mode(int_type_q[i], int_pol_q[i], int_both_q[i]))
            EDGE_POS:  ev[i] = d[i] & ~prev_q[i];
            EDGE_NEG:  ev[i] = ~d[i] & prev_q[i];
            EDGE_BOTH: ev[i] = d[i] ^ prev_q[i];
            LVL_HIGH:  ev[i] = d[i];
            LVL_LOW:   ev[i] = ~d[i];
            default:   ev[i] = 1'b0;
         endcase
      end
      if (!ev_en) ev = '0;
   end

   always_comb begin
      rd_mux = '0;
      case (reg_addr)
         GPIO_DIR:      rd_mux = 32'(dir_q);
         GPIO_OUT:      rd_mux = 32'(out_q);
         GPIO_IN:       rd_mux = 32'(d);
         GPIO_INT_EN:   rd_mux = 32'(int_en_q);
         GPIO_INT_TYPE: rd_mux = 32'(int_type_q);
         GPIO_INT_POL:  rd_mux = 32'(int_pol_q);
         GPIO_INT_BOTH: rd_mux = 32'(int_both_q);
         GPIO_INT_STAT: rd_mux = 32'(int_stat_q);
`ifdef GPIO_DEBOUNCE_EN
         GPIO_DB_PRESC: rd_mux = 32'(presc_q);
`endif
         GPIO_OUT_TYPE: rd_mux = 32'(out_type_q);
         default:       rd_mux = '0;
      endcase
   end

   always_ff @(posedge mclk) begin
      if (!h_reset_n) begin
         reg_ack    <= 1'b0;
         reg_rdata  <= '0;
         dir_q      <= '0;
         out_q      <= '0;
         out_type_q <= '0;
         pad_out_q  <= '0;
         int_en_q   <= '0;
         int_type_q <= '0;
         int_pol_q  <= '0;
         int_both_q <= '0;
      end else begin
         reg_ack   <= take;
         reg_rdata <= (take && !reg_wr) ? rd_mux : '0;
         pad_out_q <= out_q;
         if (wr_en) begin
            case (reg_addr)
               GPIO_DIR:      dir_q      <= upd(dir_q, wmask, wbits);
               GPIO_OUT:      out_q      <= upd(out_q, wmask, wbits);
               GPIO_OUT_SET:  out_q      <= out_q | wsel;
               GPIO_OUT_CLR:  out_q      <= out_q & ~wsel;
               GPIO_INT_EN:   int_en_q   <= upd(int_en_q, wmask, wbits);
               GPIO_INT_TYPE: int_type_q <= upd(int_type_q, wmask, wbits);
               GPIO_INT_POL:  int_pol_q  <= upd(int_pol_q, wmask, wbits);
               GPIO_INT_BOTH: int_both_q <= upd(int_both_q, wmask, wbits);
               GPIO_OUT_TYPE: out_type_q <= upd(out_type_q, wmask, wbits);
               default: ;
            endcase
         end
      end
   end

   // A new event on the same bit as a W1C keeps the bit set.
   always_ff @(posedge mclk) begin
      if (!h_reset_n) begin
         int_stat_q <= '0;
         prev_q     <= '0;
      end else begin
         int_stat_q <= (int_stat_q & ~w1c) | ev;
         prev_q     <= d;
      end
   end

   assign cfg_gpio_dir_sel  = dir_q;
   assign cfg_gpio_out_type = out_type_q;
   assign pad_gpio_out      = pad_out_q;
   assign gpio_intr         = int_stat_q & int_en_q;
   assign gpio_irq          = |gpio_intr;

endmodule

// File: tb/tb_gpio_ctrl_v2.sv
// Self-checking bench for gpio_ctrl_v2: vector table, randomized register
// traffic against a reference model, and hand-written interrupt/reset/debounce sequences.
module tb_gpio_ctrl_v2;

   localparam int W = 32;
   localparam int S = 2;
   localparam int DBC = 3;

`ifdef GPIO_DEBOUNCE_EN
   localparam logic [31:0] PRESC_RD = 32'h0000_2345;
`else
   localparam logic [31:0] PRESC_RD = 32'h0;
`endif

   logic          mclk = 1'b0;
   logic          h_reset_n = 1'b0;
   logic          reg_cs = 1'b0;
   logic          reg_wr = 1'b0;
   logic [3:0]    reg_addr = '0;
   logic [31:0]   reg_wdata = '0;
   logic [3:0]    reg_be = '0;
   logic [31:0]   reg_rdata;
   logic          reg_ack;
   logic [W-1:0]  cfg_gpio_dir_sel, cfg_gpio_out_type, pad_gpio_out, gpio_intr;
   logic [W-1:0]  pad_gpio_in = '0;
   logic          gpio_irq;

   int n_cmp = 0;
   int n_bad = 0;

   gpio_ctrl_v2 #(.GPIO_W(W), .SYNC_STAGES(S), .DB_CNT(DBC)) dut (
      .mclk              (mclk),
      .h_reset_n         (h_reset_n),
      .reg_cs            (reg_cs),
      .reg_wr            (reg_wr),
      .reg_addr          (reg_addr),
      .reg_wdata         (reg_wdata),
      .reg_be            (reg_be),
      .reg_rdata         (reg_rdata),
      .reg_ack           (reg_ack),
      .cfg_gpio_dir_sel  (cfg_gpio_dir_sel),
      .cfg_gpio_out_type (cfg_gpio_out_type),
      .pad_gpio_in       (pad_gpio_in),
      .pad_gpio_out      (pad_gpio_out),
      .gpio_intr         (gpio_intr),
      .gpio_irq          (gpio_irq)
   );

   always #5 mclk = ~mclk;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic bus(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] rd, output int lat);
      bit got;
      @(negedge mclk);
      reg_cs = 1'b1; reg_wr = wr; reg_addr = addr; reg_wdata = wd; reg_be = be;
      got = 1'b0; rd = '0; lat = 0;
      for (int k = 1; k <= 8 && !got; k++) begin
         @(posedge mclk); #1;
         if (reg_ack) begin got = 1'b1; rd = reg_rdata; lat = k; end
      end
      reg_cs = 1'b0; reg_wr = 1'b0;
      check("ack_seen", 32'(got), 32'd1);
      @(posedge mclk); #1;
      check("ack_single_cycle", 32'(reg_ack), 32'd0);
   endtask

   task automatic wr(input logic [3:0] addr, input logic [31:0] wd);
      logic [31:0] rd; int lat;
      bus(1'b1, addr, wd, 4'hF, rd, lat);
   endtask

   task automatic rd_chk(input string name, input logic [3:0] addr, input logic [31:0] exp);
      logic [31:0] rd; int lat;
      bus(1'b0, addr, 32'h0, 4'hF, rd, lat);
      check(name, rd, exp);
   endtask

   task automatic do_reset();
      @(negedge mclk);
      h_reset_n = 1'b0; reg_cs = 1'b0; pad_gpio_in = '0;
      repeat (3) @(negedge mclk);
      h_reset_n = 1'b1;
      repeat (S + 4) @(posedge mclk);
   endtask

   typedef struct {
      logic        wr;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        chk_pad;
      logic [31:0] exp_pad;
   } vec_t;

   vec_t vecs[$];
   logic [31:0] m[16];

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      logic [31:0] r = '0;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = 8'hFF;
      return r;
   endfunction

   initial begin
      logic [31:0] rd, mask, exp;
      int lat;
      logic [3:0] a;
      logic w;
      logic [31:0] wd;
      logic [3:0] be;
      bit any_ack;

      // ---------------- reset values ----------------
      repeat (3) @(posedge mclk);
      #1;
      check("rst_ack", 32'(reg_ack), 32'd0);
      check("rst_pad_out", pad_gpio_out, 32'h0);
      check("rst_rdata", reg_rdata, 32'h0);
      do_reset();

      // ---------------- vector table ----------------
      vecs.push_back('{1'b1, 4'd1,  32'hA5A5_A5A5, 4'b0011, 1'b0, 32'h0,         1'b0, 32'h0});
      vecs.push_back('{1'b0, 4'd1,  32'h0,         4'hF,    1'b1, 32'h0000_A5A5, 1'b1, 32'h0000_A5A5});
      vecs.push_back('{1'b1, 4'd1,  32'h0000_000F, 4'hF,    1'b0, 32'h0,         1'b0, 32'h0});
      vecs.push_back('{1'b1, 4'd2,  32'h0000_0030, 4'hF,    1'b0, 32'h0,         1'b0, 32'h0});
      vecs.push_back('{1'b1, 4'd3,  32'h0000_0003, 4'hF,    1'b0, 32'h0,         1'b1, 32'h0000_003C});
      vecs.push_back('{1'b0, 4'd1,  32'h0,         4'hF,    1'b1, 32'h0000_003C, 1'b1, 32'h0000_003C});
      vecs.push_back('{1'b0, 4'd2,  32'h0,         4'hF,    1'b1, 32'h0,         1'b0, 32'h0});
      vecs.push_back('{1'b0, 4'd3,  32'h0,         4'hF,    1'b1, 32'h0,         1'b0, 32'h0});
      vecs.push_back('{1'b1, 4'd0,  32'h1234_5678, 4'b1100, 1'b0, 32'h0,         1'b0, 32'h0});
      vecs.push_back('{1'b0, 4'd0,  32'h0,         4'hF,    1'b1, 32'h1234_0000, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 4'd12, 32'hFFFF_FFFF, 4'hF,    1'b0, 32'h0,         1'b0, 32'h0});
      vecs.push_back('{1'b0, 4'd12, 32'h0,         4'hF,    1'b1, 32'h0,         1'b0, 32'h0});
      vecs.push_back('{1'b0, 4'd15, 32'h0,         4'hF,    1'b1, 32'h0,         1'b0, 32'h0});
      vecs.push_back('{1'b1, 4'd4,  32'hFFFF_FFFF, 4'hF,    1'b0, 32'h0,         1'b0, 32'h0});
      vecs.push_back('{1'b0, 4'd4,  32'h0,         4'hF,    1'b1, 32'h0,         1'b0, 32'h0});
      vecs.push_back('{1'b1, 4'd11, 32'hDEAD_BEEF, 4'hF,    1'b0, 32'h0,         1'b0, 32'h0});
      vecs.push_back('{1'b0, 4'd11, 32'h0,         4'hF,    1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 4'd10, 32'h0001_2345, 4'hF,    1'b0, 32'h0,         1'b0, 32'h0});
      vecs.push_back('{1'b0, 4'd10, 32'h0,         4'hF,    1'b1, PRESC_RD,      1'b0, 32'h0});
      vecs.push_back('{1'b1, 4'd10, 32'h0,         4'hF,    1'b0, 32'h0,         1'b0, 32'h0});

      for (int i = 0; i < vecs.size(); i++) begin
         bus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, lat);
         check($sformatf("vec%0d_ack_latency", i), 32'(lat), 32'd1);
         if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         if (vecs[i].chk_pad) check($sformatf("vec%0d_pad_out", i), pad_gpio_out, vecs[i].exp_pad);
      end
      check("tbl_dir_sel", cfg_gpio_dir_sel, 32'h1234_0000);
      check("tbl_out_type", cfg_gpio_out_type, 32'hDEAD_BEEF);

      // ---------------- randomized register traffic vs model ----------------
      do_reset();
      for (int i = 0; i < 16; i++) m[i] = '0;
      for (int it = 0; it < 200; it++) begin
         a = 4'($urandom_range(0, 15));
         if (a == 4'd10) a = 4'd9;
         w = 1'($urandom_range(0, 1));
         wd = $urandom;
         be = 4'($urandom_range(0, 15));
         bus(w, a, wd, be, rd, lat);
         if (w) begin
            mask = lane_mask(be) & wd;
            case (a)
               4'd0, 4'd1, 4'd5, 4'd6, 4'd7, 4'd8, 4'd11:
                  m[a] = (m[a] & ~lane_mask(be)) | mask;
               4'd2: m[1] = m[1] | mask;
               4'd3: m[1] = m[1] & ~mask;
               4'd9: m[9] = m[9] & ~mask;
               default: ;
            endcase
         end else begin
            case (a)
               4'd0, 4'd1, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11: exp = m[a];
               default: exp = 32'h0;
            endcase
            check($sformatf("rnd%0d_rd_a%0d", it, a), rd, exp);
         end
         // Inputs stay low, so only level-low pins keep raising status.
         m[9] = m[9] | (m[6] & ~m[7]);
         check($sformatf("rnd%0d_pad_out", it), pad_gpio_out, m[1]);
         check($sformatf("rnd%0d_dir", it), cfg_gpio_dir_sel, m[0]);
         check($sformatf("rnd%0d_out_type", it), cfg_gpio_out_type, m[11]);
         check($sformatf("rnd%0d_intr", it), gpio_intr, m[9] & m[5]);
         check($sformatf("rnd%0d_irq", it), 32'(gpio_irq), 32'(|(m[9] & m[5])));
      end

      // ---------------- reset with pins high, released mid-access ----------------
      @(negedge mclk);
      h_reset_n = 1'b0;
      pad_gpio_in = '1;
      reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = 4'd7; reg_wdata = 32'hFFFF_FFFF; reg_be = 4'hF;
      any_ack = 1'b0;
      repeat (4) begin
         @(posedge mclk); #1;
         if (reg_ack) any_ack = 1'b1;
      end
      check("rst_no_ack", 32'(any_ack), 32'd0);
      check("rst_pad_out_zero", pad_gpio_out, 32'h0);
      check("rst_dir_zero", cfg_gpio_dir_sel, 32'h0);
      check("rst_intr_zero", gpio_intr, 32'h0);
      check("rst_irq_zero", 32'(gpio_irq), 32'd0);
      @(negedge mclk);
      h_reset_n = 1'b1;
      @(posedge mclk); #1;
      check("rst_release_ack", 32'(reg_ack), 32'd1);
      reg_cs = 1'b0; reg_wr = 1'b0;
      repeat (20) @(posedge mclk);
      rd_chk("rst_pol_written", 4'd7, 32'hFFFF_FFFF);
      rd_chk("rst_no_stat", 4'd9, 32'h0);
      rd_chk("rst_in_high", 4'd4, 32'hFFFF_FFFF);

      // ---------------- edge interrupt, both edges, pin 3 ----------------
      do_reset();
      wr(4'd5, 32'h0000_0008);
      wr(4'd8, 32'h0000_0008);
      pad_gpio_in[3] = 1'b1; repeat (6) @(posedge mclk);
      pad_gpio_in[3] = 1'b0; repeat (6) @(posedge mclk);
      rd_chk("edge_pulse_stat", 4'd9, 32'h0000_0008);
      check("edge_irq_set", 32'(gpio_irq), 32'd1);
      wr(4'd9, 32'h0000_0008);
      rd_chk("edge_w1c_stat", 4'd9, 32'h0);
      check("edge_irq_clear", 32'(gpio_irq), 32'd0);
      pad_gpio_in[3] = 1'b1; repeat (6) @(posedge mclk);
      wr(4'd9, 32'h0000_0008);
      rd_chk("edge_rise_cleared", 4'd9, 32'h0);
      pad_gpio_in[3] = 1'b0; repeat (6) @(posedge mclk);
      rd_chk("edge_fall_stat", 4'd9, 32'h0000_0008);
      check("edge_fall_intr", gpio_intr, 32'h0000_0008);
      wr(4'd9, 32'h0000_0008);

      // ---------------- level high vs W1C, pin 5 ----------------
      wr(4'd6, 32'h0000_0020);
      wr(4'd7, 32'h0000_0020);
      wr(4'd5, 32'h0000_0028);
      pad_gpio_in[5] = 1'b1; repeat (6) @(posedge mclk);
      rd_chk("lvl_stat_set", 4'd9, 32'h0000_0020);
      wr(4'd9, 32'h0000_0020);
      rd_chk("lvl_w1c_held", 4'd9, 32'h0000_0020);
      check("lvl_irq", 32'(gpio_irq), 32'd1);
      pad_gpio_in[5] = 1'b0; repeat (6) @(posedge mclk);
      wr(4'd9, 32'h0000_0020);
      rd_chk("lvl_w1c_done", 4'd9, 32'h0);

      // ---------------- posedge event on pin 6 coinciding with W1C ----------------
      wr(4'd7, 32'h0000_0060);
      rd_chk("coinc_pre", 4'd9, 32'h0);
      @(negedge mclk);
      pad_gpio_in[6] = 1'b1;
      repeat (S - 1) @(negedge mclk);
      bus(1'b1, 4'd9, 32'h0000_0040, 4'hF, rd, lat);
      rd_chk("coinc_set_wins", 4'd9, 32'h0000_0040);
      wr(4'd9, 32'h0000_0040);
      rd_chk("coinc_later_w1c", 4'd9, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
      // ---------------- debounce, DB_PRESC = 9 ----------------
      do_reset();
      wr(4'd10, 32'h0000_0009);
      @(negedge mclk);
      pad_gpio_in[0] = 1'b1; repeat (20) @(negedge mclk);
      pad_gpio_in[0] = 1'b0; repeat (40) @(negedge mclk);
      rd_chk("db_glitch_rejected", 4'd4, 32'h0);
      pad_gpio_in[0] = 1'b1; repeat (15) @(negedge mclk);
      rd_chk("db_not_yet", 4'd4, 32'h0);
      repeat (25) @(negedge mclk);
      rd_chk("db_accepted", 4'd4, 32'h0000_0001);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gpio_ctrl_v2.md
Name: gpio_ctrl_v2

Overview:
Parametrised next-generation GPIO controller with a byte-enabled register-bus slave. Per pin it provides:
- direction and output data, with atomic set/clear
- a configurable input synchroniser and prescaled debounce filter
- five interrupt modes: posedge, negedge, both edges, level-high, level-low
- a sticky W1C status register

It sits under the pinmux block, between the register bus and the pad ring.

Parameters:
GPIO_W, 32, number of pins (1..32); register bits above GPIO_W-1 read 0 and ignore writes
SYNC_STAGES, 2, input synchroniser flops (2..3)
DB_CNT, 3, consecutive prescaler ticks a changed input must hold before it is accepted (1..15)

Ports:
mclk  input  1  system clock
h_reset_n  input  1  reset; synchronous, active-low, sampled on the rising edge of mclk
reg_cs  input  1  register access request
reg_wr  input  1  1 = write, 0 = read
reg_addr  input  4  word address
reg_wdata  input  32  write data
reg_be  input  4  byte enables
reg_rdata  output  32  read data, registered
reg_ack  output  1  one-cycle access acknowledge
cfg_gpio_dir_sel  output  GPIO_W  1 = pin drives
cfg_gpio_out_type  output  GPIO_W  1 = ws281x-driven pin
pad_gpio_in  input  GPIO_W  raw pad inputs (asynchronous)
pad_gpio_out  output  GPIO_W  output data register
gpio_intr  output  GPIO_W  per-pin pending interrupt (INT_STAT & INT_EN)
gpio_irq  output  1  OR-reduction of gpio_intr

Behaviour:
- Reset (synchronous, active-low): all registers, synchroniser, debounce counters, reg_ack, reg_rdata and every output go to 0.
- Bus handshake:
  - An access is taken on the edge where reg_cs=1 and reg_ack=0.
  - reg_ack=1 on the following cycle for exactly one cycle, with reg_rdata valid.
  - The master drops reg_cs after ack; back-to-back accesses therefore take 2 cycles each.
  - Writes update only bytes with reg_be set. Register effects are visible from the cycle reg_ack is high.
- Register map (word address):
  - 0 DIR
  - 1 OUT
  - 2 OUT_SET: W1S into OUT, reads 0
  - 3 OUT_CLR: W1C into OUT, reads 0
  - 4 IN: debounced inputs, read-only
  - 5 INT_EN
  - 6 INT_TYPE: 1 = level, 0 = edge
  - 7 INT_POL: edge 1 = pos / 0 = neg; level 1 = high / 0 = low
  - 8 INT_BOTH: edge-type pins trigger on both edges, overrides POL
  - 9 INT_STAT: W1C
  - 10 DB_PRESC [15:0]
  - 11 OUT_TYPE
  - 12..15 read 0, writes ignored
- Input path: pad_gpio_in passes through SYNC_STAGES flops. Debounced value d is then produced:
  - A shared prescaler pulses tick every DB_PRESC+1 cycles.
  - Per pin: if sync==d, counter clears. Otherwise the counter increments on tick; on reaching DB_CNT, d<=sync and the counter clears.
  - DB_PRESC==0 bypasses the filter: d=sync, counters held at 0.
  - Writing DB_PRESC clears the prescaler and all debounce counters.
- Startup window:
  - For SYNC_STAGES+1 cycles after reset release, d loads sync directly and no events are generated.
  - A pin held high through reset therefore raises no posedge interrupt.
- Edge detection:
  - Compares d with registered prev_d, one cycle after d changes.
  - Edge events set INT_STAT regardless of INT_EN; INT_EN masks only gpio_intr.
- Level mode: INT_STAT is set every cycle the level condition holds, so W1C only takes effect once the condition is gone.
- Simultaneous set event and W1C on the same bit: set wins.
- OUT_SET and OUT_CLR write OUT; OUT_TYPE and DIR feed the pad ring unchanged.
- pad_gpio_out = OUT, registered; latency 1 cycle after ack.
- Changing INT_TYPE or INT_POL does not clear INT_STAT.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- Defined: prescaler, debounce counters and the DB_PRESC register exist as above.
- Undefined:
  - The filter logic is not built and d = synchronised input.
  - Address 10 reads 0 and ignores writes.
  - All other behaviour is identical.

Decomposition:
- Package gpio_pkg:
  - register address localparams (GPIO_DIR..GPIO_OUT_TYPE)
  - typedef gpio_int_mode_e {EDGE_POS, EDGE_NEG, EDGE_BOTH, LVL_HIGH, LVL_LOW}
  - prescaler width constant DB_PRESC_W=16
- Sub-module gpio_debounce: the synchroniser plus per-pin filter, instantiated once with vector width GPIO_W. The prescaler lives in the top level.

Test Plan:
- Bus/byte-enable: write 0xA5A5_A5A5 to OUT with be=4'b0011, then read → 0x0000_A5A5; reg_ack is a single-cycle pulse one cycle after cs.
- Atomic: OUT=0x0F, write OUT_SET 0x30, then OUT_CLR 0x03 → pad_gpio_out=0x3C; reads of addr 2 and 3 return 0.
- Debounce: DB_PRESC=9, DB_CNT=3; pin0 glitches high for 20 cycles → IN bit0 stays 0; pin0 held high 40 cycles → IN bit0=1 within SYNC_STAGES+30..40 cycles of the edge.
- Edge interrupt: pin3 INT_EN=1, TYPE=0, BOTH=1; pulse pin3 high then low (DB_PRESC=0) → INT_STAT bit3 set; W1C clears it; next falling edge sets it again; gpio_irq follows.
- Level vs W1C: pin5 LVL_HIGH with input held high, write 1 to INT_STAT bit5 → bit stays 1; drop input, W1C → bit5=0. An edge event coinciding with W1C leaves the bit 1.
- Reset: pins driven 0xFFFF_FFFF through reset with h_reset_n deasserted mid-access → no ack, all outputs 0, no INT_STAT bits set after release.
